sd_blk_arbiter: RTL and testbench
=================================

# sd_blk_arbiter

Shares one MiSTer HPS SD block-level port (one image slot) between two requesters: client A (hard-disk SD controller) and client B (floppy controller). Grants the port to one client per whole sector transaction, forwards ack and buffer traffic to the granted client only, and alternates priority fairly. Sits between the client controllers and the top-level `sd_*` signals of the image slot.

## Interface
- `TIMEOUT`, 24'd5_000_000: clock cycles allowed from host request to host ack before the transaction is abandoned.
- `clock`  in  1  system clock, rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `a_lba`  in  32  client A sector address.
- `a_rd`, `a_wr`  in  1 each  client A requests, level, held until `a_ack`.
- `a_ack`  out  1  host ack routed to A.
- `a_buff_wr`  out  1  host buffer write strobe routed to A.
- `a_buff_din`  in  8  A's buffer read data for host writes.
- `b_lba`, `b_rd`, `b_wr`, `b_ack`, `b_buff_wr`, `b_buff_din`: same as A, for client B.
- `sd_lba`  out  32  host sector address.
- `sd_rd`, `sd_wr`  out  1 each  host requests.
- `sd_ack`  in  1  host ack.
- `sd_buff_wr`  in  1  host buffer write strobe.
- `sd_buff_din`  out  8  data to host, muxed from the granted client.
- `grant`  out  2  one-hot owner: 01 = A, 10 = B, 00 = idle.
- `timeout_err`  out  1  one-cycle pulse on an abandoned transaction.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, XFER, RELEASE.
- IDLE: a client is requesting when `rd|wr` is high. One requester is granted directly. With both requesting, grant goes to the client named by `prio` (reset = A). Latch the granted client's lba and op into `sd_lba` and an internal op register, then go to ISSUE.
- A client asserting both rd and wr is treated as a read.
- ISSUE: assert `sd_rd` or `sd_wr` and clear the timer. Go to WAIT_ACK.
- WAIT_ACK: when `sd_ack` is high, drop `sd_rd`/`sd_wr` and go to XFER. If the timer reaches `TIMEOUT-1` first, drop the request, pulse `timeout_err` and go to RELEASE.
- XFER: hold the grant. Leave for RELEASE on the cycle `sd_ack` is sampled low.
- RELEASE: set `grant` to 00. Set `prio` to the client that was not just served. Return to IDLE.
- Routing is combinational from the `grant` register:
  - `x_ack = sd_ack & grant[x]`
  - `x_buff_wr = sd_buff_wr & grant[x]`
  - `sd_buff_din` = A's data if `grant[0]`, B's data if `grant[1]`, 8'h00 if idle.
- A client dropping its request after grant does not abort the transaction; the host transaction always completes.
- `sd_lba` stays stable from ISSUE through XFER. It is not updated while not in IDLE.

## Timing
- Reset values: all outputs 0, `grant` = 00, `prio` = A, state IDLE, timer 0.
- Reset mid-transaction returns immediately to IDLE with `sd_rd`/`sd_wr` low.
- Grant latency: request sampled in IDLE at edge N sets `grant` and `sd_lba` at N. `sd_rd`/`sd_wr` go high at edge N+1.
- `sd_rd`/`sd_wr` fall on the first edge at which `sd_ack` is sampled high.
- Release: `grant` = 00 one edge after ack is sampled low. The earliest next grant is the following edge. Back-to-back transactions therefore have ≥2 idle cycles between `sd_ack` falling and the next `sd_rd`.
- Timer: 24-bit, saturating at `TIMEOUT-1`; no wrap.
- A timeout fires exactly `TIMEOUT` cycles after entering WAIT_ACK.
- `sd_ack` arriving in the same cycle as the timer terminal count: ack wins, no error.
- `sd_ack` high while in IDLE, RELEASE or ISSUE (stale): ignored, not routed to any client.

## Structure
- Package `sd_arb_pkg` holds:
  - the state enum `sd_arb_state_t`;
  - localparams `CLI_A = 0` and `CLI_B = 1`;
  - `OP_RD` and `OP_WR`.
- Single module. No sub-module is needed; the timer and mux are inline.

## Test plan
- Read by A only, lba 32'h0000_0123, host acks 3 cycles after `sd_rd`, 512 `sd_buff_wr` strobes -> `sd_lba` = 0x123, `grant` = 01, `a_buff_wr` pulses 512 times, `b_buff_wr` never pulses, `grant` = 00 after ack falls.
- A and B request on the same cycle after reset -> A served first. B is granted 2 cycles after A's ack falls, with `sd_lba` = b_lba.
- A and B continuously requesting -> grants alternate A, B, A, B over 4 transactions.
- Write by B, `b_buff_din` = 8'h5A -> `sd_wr` high, `sd_buff_din` = 8'h5A during the ack window, `a_ack` stays 0.
- No host ack with `TIMEOUT` = 16 -> `sd_rd` drops and `timeout_err` pulses exactly 16 cycles after WAIT_ACK entry; the other client is granted next.
- `RESET_N` low during XFER -> all outputs 0 asynchronously. After release a new A request is granted normally.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and constants for the SD block-port arbiter
package sd_arb_pkg;

  // Arbiter sequencing, one pass per host sector transaction
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_XFER     = 3'd3,
    ST_RELEASE  = 3'd4
  } sd_arb_state_t;

  // Bit positions of each client inside the one-hot grant vector
  localparam int CLI_A = 0;
  localparam int CLI_B = 1;

  // Latched operation of the granted transaction
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // A client raising both rd and wr is served as a read
  function automatic logic req_op(input logic rd, input logic wr);
    return (wr & ~rd) ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/sd_blk_arbiter.sv
// rtl/sd_blk_arbiter.sv - shares one HPS SD block port between two sector clients
module sd_blk_arbiter
  import sd_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic        clock,
  input  logic        RESET_N,

  input  logic [31:0] a_lba,
  input  logic        a_rd,
  input  logic        a_wr,
  output logic        a_ack,
  output logic        a_buff_wr,
  input  logic [7:0]  a_buff_din,

  input  logic [31:0] b_lba,
  input  logic        b_rd,
  input  logic        b_wr,
  output logic        b_ack,
  output logic        b_buff_wr,
  input  logic [7:0]  b_buff_din,

  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [23:0] TERM = TIMEOUT - 24'd1;

  sd_arb_state_t state;
  logic          prio;     // 0: A wins a tie, 1: B wins a tie
  logic          op;
  logic [23:0]   timer;

  logic a_req;
  logic b_req;
  logic pick_b;
  logic ack_window;

  assign a_req  = a_rd | a_wr;
  assign b_req  = b_rd | b_wr;
  assign pick_b = b_req & (~a_req | prio);

  // Host ack only belongs to a client while its transaction is actually waiting or moving data
  assign ack_window = (state == ST_WAIT_ACK) || (state == ST_XFER);

  assign a_ack       = sd_ack & grant[CLI_A] & ack_window;
  assign b_ack       = sd_ack & grant[CLI_B] & ack_window;
  assign a_buff_wr   = sd_buff_wr & grant[CLI_A];
  assign b_buff_wr   = sd_buff_wr & grant[CLI_B];
  assign sd_buff_din = grant[CLI_A] ? a_buff_din :
                       grant[CLI_B] ? b_buff_din : 8'h00;

  // Transaction sequencer: grant, issue, wait for ack with timeout, transfer, release
  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      prio        <= 1'b0;
      op          <= OP_RD;
      timer       <= 24'd0;
      grant       <= 2'b00;
      sd_lba      <= 32'd0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (a_req || b_req) begin
            grant  <= pick_b ? 2'b10 : 2'b01;
            sd_lba <= pick_b ? b_lba : a_lba;
            op     <= pick_b ? req_op(b_rd, b_wr) : req_op(a_rd, a_wr);
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sd_rd <= (op == OP_RD);
          sd_wr <= (op == OP_WR);
          timer <= 24'd0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_XFER;
          end else if (timer == TERM) begin
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_RELEASE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        ST_XFER: begin
          if (!sd_ack) begin
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          grant <= 2'b00;
          prio  <= grant[CLI_A];
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// tb/tb_sd_blk_arbiter.sv - randomized self-checking bench for sd_blk_arbiter
module tb_sd_blk_arbiter;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] a_lba = '0, b_lba = '0;
  logic        a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
  logic        a_ack, b_ack, a_buff_wr, b_buff_wr;
  logic [7:0]  a_buff_din = '0, b_buff_din = '0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;
  logic [1:0]  grant;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int cnt_abw = 0, cnt_bbw = 0, cnt_to = 0;
  int exp_prio = 0;

  always #5 clock = ~clock;

  sd_blk_arbiter #(.TIMEOUT(24'd16)) dut (
    .clock(clock), .RESET_N(RESET_N),
    .a_lba(a_lba), .a_rd(a_rd), .a_wr(a_wr), .a_ack(a_ack),
    .a_buff_wr(a_buff_wr), .a_buff_din(a_buff_din),
    .b_lba(b_lba), .b_rd(b_rd), .b_wr(b_wr), .b_ack(b_ack),
    .b_buff_wr(b_buff_wr), .b_buff_din(b_buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters sampled mid-cycle, well clear of the rising edge
  always @(negedge clock) begin
    #3;
    if (a_buff_wr === 1'b1) cnt_abw++;
    if (b_buff_wr === 1'b1) cnt_bbw++;
    if (timeout_err === 1'b1) cnt_to++;
  end

  task automatic req(input int cli, input bit rd, input bit wr, input logic [31:0] lba, input logic [7:0] din);
    if (cli == 0) begin
      a_rd = rd; a_wr = wr; a_lba = lba; a_buff_din = din;
    end else begin
      b_rd = rd; b_wr = wr; b_lba = lba; b_buff_din = din;
    end
  endtask

  task automatic drop(input int cli);
    if (cli == 0) begin a_rd = 1'b0; a_wr = 1'b0; end
    else begin b_rd = 1'b0; b_wr = 1'b0; end
  endtask

  function automatic bit requesting(input int cli);
    return (cli == 0) ? (a_rd | a_wr) : (b_rd | b_wr);
  endfunction

  // Reference rule: lone requester wins; on contention the priority holder wins
  function automatic int winner();
    if (requesting(0) && requesting(1)) return exp_prio;
    return requesting(1) ? 1 : 0;
  endfunction

  // One host transaction as seen from the host side, checked against the model
  task automatic run_txn(input int ack_delay, input int nstr, input bit do_ack, input bit rearm, output int w);
    int c, gcyc, bad, b_abw, b_bbw, b_to;
    logic [31:0] elba;
    bit eop_wr;
    logic [7:0] edin;
    w      = winner();
    elba   = w ? b_lba : a_lba;
    eop_wr = w ? (b_wr & ~b_rd) : (a_wr & ~a_rd);
    edin   = w ? b_buff_din : a_buff_din;
    b_abw = cnt_abw; b_bbw = cnt_bbw; b_to = cnt_to;
    gcyc = (grant != 2'b00 && !(sd_rd | sd_wr)) ? 0 : -1;
    c = 0;
    while (!(sd_rd | sd_wr) && c < 40) begin
      @(negedge clock); #1; c++;
      if (grant != 2'b00 && !(sd_rd | sd_wr) && gcyc < 0) gcyc = c;
    end
    if (!(sd_rd | sd_wr)) begin
      chk("req_seen", 0, 1);
      return;
    end
    chk("grant_to_req", c - gcyc, 1);
    chk("grant", grant, w ? 32'd2 : 32'd1);
    chk("lba", sd_lba, elba);
    chk("op_wr", sd_wr, eop_wr);
    chk("op_rd", sd_rd, !eop_wr);
    if (do_ack) begin
      repeat (ack_delay) begin @(negedge clock); #1; end
      chk("req_held", sd_rd | sd_wr, 1);
      sd_ack = 1'b1;
      drop(w);
      #1;
      chk("ack_route", {a_ack, b_ack}, w ? 32'd1 : 32'd2);
      @(negedge clock); #1;
      chk("req_drop", sd_rd | sd_wr, 0);
      bad = 0;
      for (int i = 0; i < nstr; i++) begin
        sd_buff_wr = 1'b1; #1;
        if (sd_buff_din !== edin || sd_lba !== elba) bad++;
        @(negedge clock); #1;
      end
      chk("xfer_data", bad, 0);
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      if (rearm) req(w, 1'b1, 1'b0, $urandom, 8'($urandom));
      @(negedge clock); #1;
      chk("grant_hold", grant, w ? 32'd2 : 32'd1);
      @(negedge clock); #1;
      chk("grant_rel", grant, 0);
      chk("bw_win", w ? (cnt_bbw - b_bbw) : (cnt_abw - b_abw), nstr);
      chk("bw_other", w ? (cnt_abw - b_abw) : (cnt_bbw - b_bbw), 0);
      chk("no_timeout", cnt_to - b_to, 0);
    end else begin
      c = 0;
      while (timeout_err !== 1'b1 && c < TMO + 8) begin @(negedge clock); #1; c++; end
      chk("to_cycle", c, TMO);
      chk("to_drop", sd_rd | sd_wr, 0);
      @(negedge clock); #1;
      chk("to_pulse", timeout_err, 0);
      chk("to_rel", grant, 0);
      chk("to_count", cnt_to - b_to, 1);
    end
    exp_prio = 1 - w;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, w1, c, v;
    repeat (3) @(negedge clock); #1;
    chk("rst_grant", grant, 0);
    chk("rst_rd", sd_rd, 0);
    chk("rst_wr", sd_wr, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_din", sd_buff_din, 0);
    RESET_N = 1'b1;
    @(negedge clock); #1;

    // Stale ack in idle reaches nobody and starts nothing
    sd_ack = 1'b1; #1;
    chk("stale_ack", {a_ack, b_ack}, 0);
    @(negedge clock); #1;
    chk("stale_grant", grant, 0);
    sd_ack = 1'b0;
    @(negedge clock); #1;

    // Simultaneous request after reset: A first, then B two cycles after release
    req(0, 1'b1, 1'b0, 32'h0000_00A0, 8'h21);
    req(1, 1'b1, 1'b0, 32'h0000_00B0, 8'h22);
    run_txn(2, 4, 1'b1, 1'b0, w);
    chk("tie_first_a", w, 0);
    @(negedge clock); #1;
    chk("b_grant_next", grant, 2);
    chk("b_lba_next", sd_lba, 32'h0000_00B0);
    run_txn(2, 4, 1'b1, 1'b0, w);
    chk("tie_second_b", w, 1);

    // Continuous requests alternate A, B, A, B
    req(0, 1'b1, 1'b0, $urandom, 8'($urandom));
    req(1, 1'b1, 1'b0, $urandom, 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 3, 1'b1, i < 2, w);
      chk("alternate", w, i % 2);
    end

    // Sector read by A alone with a full 512-byte buffer
    req(0, 1'b1, 1'b0, 32'h0000_0123, 8'h11);
    run_txn(3, 512, 1'b1, 1'b0, w);

    // Write by B: host sees B's buffer data
    req(1, 1'b0, 1'b1, 32'h0000_CAFE, 8'h5A);
    run_txn(4, 8, 1'b1, 1'b0, w);

    // Ack on the terminal count cycle beats the timeout
    req(0, 1'b1, 1'b0, 32'h0000_0777, 8'h33);
    run_txn(TMO - 1, 2, 1'b1, 1'b0, w);

    // Timeout with both waiting: the other client goes next, then the abandoned one retries
    req(0, 1'b1, 1'b0, 32'h0001_0000, 8'h44);
    req(1, 1'b0, 1'b1, 32'h0002_0000, 8'h55);
    run_txn(0, 0, 1'b0, 1'b0, w1);
    run_txn(1, 2, 1'b1, 1'b0, w);
    chk("to_other_next", w, 1 - w1);
    run_txn(1, 2, 1'b1, 1'b0, w);
    chk("to_retry", w, w1);

    // Reset during the data phase clears everything immediately
    req(0, 1'b0, 1'b1, 32'h0000_0077, 8'h3C);
    c = 0;
    while (!(sd_rd | sd_wr) && c < 40) begin @(negedge clock); #1; c++; end
    chk("rst_seq_req", sd_wr, 1);
    sd_ack = 1'b1;
    @(negedge clock); #1;
    sd_buff_wr = 1'b1;
    @(negedge clock); #1;
    chk("xfer_a_ack", a_ack, 1);
    RESET_N = 1'b0; #1;
    chk("arst_grant", grant, 0);
    chk("arst_req", {sd_rd, sd_wr}, 0);
    chk("arst_lba", sd_lba, 0);
    chk("arst_route", {a_ack, b_ack, a_buff_wr, b_buff_wr}, 0);
    chk("arst_din", sd_buff_din, 0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    drop(0);
    @(negedge clock); #1;
    RESET_N = 1'b1;
    exp_prio = 0;
    @(negedge clock); #1;
    chk("arst_idle", grant, 0);
    req(0, 1'b1, 1'b0, 32'h0000_0456, 8'h99);
    run_txn(1, 3, 1'b1, 1'b0, w);

    // Random traffic: new requests only from idle clients, including rd+wr combos
    for (int n = 0; n < 30; n++) begin
      for (int cli = 0; cli < 2; cli++) begin
        if (!requesting(cli) && $urandom_range(0, 1) == 1) begin
          v = $urandom_range(1, 3);
          req(cli, v[0], v[1], $urandom, 8'($urandom));
        end
      end
      if (!requesting(0) && !requesting(1)) begin
        v = $urandom_range(1, 3);
        req($urandom_range(0, 1), v[0], v[1], $urandom, 8'($urandom));
      end
      run_txn($urandom_range(0, TMO - 2), $urandom_range(0, 20), 1'b1, 1'b0, w);
    end
    while (requesting(0) || requesting(1)) run_txn(1, 1, 1'b1, 1'b0, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
